// File: rtl/joy_pkg.sv
// joy_pkg: shared state encoding, button bit positions and slice helper for the serial pad reader
package joy_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;
  localparam int JB_R  = 0;
  localparam int JB_LT = 1;
  localparam int JB_DN = 2;
  localparam int JB_UP = 3;
  localparam int JB_A  = 4;
  localparam int JB_B  = 5;
  localparam int JB_C  = 6;
  localparam int JB_D  = 7;
  localparam int JB_E  = 8;
  localparam int JB_F  = 9;
  localparam int JB_L  = 10;
  localparam int JB_S  = 11;
  function automatic int slice_lo(input int p, input int bits);
    return p * bits;
  endfunction
endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: publishes a pad word only after DEBOUNCE consecutive identical frames
module joy_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic [15:0] din,
  output logic [15:0] dout
);
  logic [15:0] prev;
  logic [3:0]  cnt;
  logic [3:0]  ncnt;
  assign ncnt = din != prev ? 4'd1 : cnt >= 4'(DEBOUNCE) ? cnt : cnt + 4'd1;
  // run-length of identical frames, output follows once the run is long enough
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= '0;
      cnt  <= '0;
      dout <= '0;
    end else if (strobe) begin
      prev <= din;
      cnt  <= ncnt;
      if (ncnt >= 4'(DEBOUNCE)) dout <= din;
    end
endmodule

// File: rtl/joy_serial_multi.sv
// joy_serial_multi: scans a daisy-chained shift-register pad adapter and publishes debounced per-player words
module joy_serial_multi import joy_pkg::*; #(
  parameter int PLAYERS   = 2,
  parameter int PAD_BITS  = 12,
  parameter int CLK_DIV   = 24,
  parameter int FRAME_GAP = 1000,
  parameter int DEBOUNCE  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  joy_data,
  output logic                  joy_clk,
  output logic                  joy_load,
  output logic [PLAYERS*16-1:0] joystick,
  output logic [PLAYERS-1:0]    present,
  output logic                  frame_done
);
  localparam int NB = PLAYERS * PAD_BITS;
  localparam int CW = $clog2((NB > FRAME_GAP ? NB : FRAME_GAP) + 1);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0]         pre;
  logic                  tick;
  state_t                state, nstate;
  logic [CW-1:0]         idx, nidx;
  logic [NB-1:0]         shift;
  logic [PLAYERS*16-1:0] cand;
  logic [PLAYERS-1:0]    live;
  assign tick = pre == PW'(CLK_DIV - 1);
  // half-period prescaler, free running
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  // next state: every phase advances on tick except the single-cycle latch
  always_comb begin
    nstate = state;
    nidx   = idx;
    if (state == LATCH) begin
      nstate = GAP;
      nidx   = '0;
    end else if (tick)
      case (state)
        IDLE:     nstate = enable ? LOAD : IDLE;
        LOAD:     begin nstate = SHIFT_LO; nidx = '0; end
        SHIFT_LO: nstate = SHIFT_HI;
        SHIFT_HI: begin nidx = idx + 1'b1; nstate = nidx == CW'(NB) ? LATCH : SHIFT_LO; end
        GAP:      begin nidx = idx + 1'b1; nstate = nidx == CW'(FRAME_GAP) ? IDLE : GAP; end
        default:  nstate = IDLE;
      endcase
  end
  // state, counter and registered chain control lines
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      joy_clk  <= 1'b1;
      joy_load <= 1'b1;
    end else begin
      state    <= nstate;
      idx      <= nidx;
      joy_clk  <= nstate != SHIFT_LO;
      joy_load <= nstate != LOAD;
    end
  // sample at the end of each low phase; first bit on the wire lands in bit 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) shift <= '0;
    else if (tick && state == SHIFT_LO) shift <= {joy_data, shift[NB-1:1]};
  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [PAD_BITS-1:0] w;
    assign w = ~shift[slice_lo(p, PAD_BITS) +: PAD_BITS];
    assign live[p] = ~&w;
    assign cand[16*p +: 16] = live[p] ? 16'(w) : 16'h0;
    joy_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk(clk),
      .reset_n(reset_n),
      .strobe(state == LATCH),
      .din(cand[16*p +: 16]),
      .dout(joystick[16*p +: 16])
    );
  end
  // presence is taken straight from the latched frame; done pulses alongside the new words
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      present    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == LATCH;
      if (state == LATCH) present <= live;
    end
endmodule

// File: tb/tb_joy_serial_multi.sv
// tb_joy_serial_multi: randomized scenario bench with shift-register pad models and a frame-history reference
module tb_joy_serial_multi;
  localparam int CD = 4;
  localparam int DA = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, en_a, jd_a, jc_a, jl_a, fd_a;
  logic [31:0] js_a;
  logic [1:0] pr_a;
  logic rst_b, en_b, jd_b, jc_b, jl_b, fd_b;
  logic [63:0] js_b;
  logic [3:0] pr_b;
  joy_serial_multi #(.PLAYERS(2), .PAD_BITS(12), .CLK_DIV(CD), .FRAME_GAP(2), .DEBOUNCE(DA)) u_a (
    .clk(clk), .reset_n(rst_a), .enable(en_a), .joy_data(jd_a), .joy_clk(jc_a),
    .joy_load(jl_a), .joystick(js_a), .present(pr_a), .frame_done(fd_a));
  joy_serial_multi #(.PLAYERS(4), .PAD_BITS(16), .CLK_DIV(CD), .FRAME_GAP(2), .DEBOUNCE(1)) u_b (
    .clk(clk), .reset_n(rst_b), .enable(en_b), .joy_data(jd_b), .joy_clk(jc_b),
    .joy_load(jl_b), .joystick(js_b), .present(pr_b), .frame_done(fd_b));
  int pass_cnt = 0;
  int total = 0;
  logic [11:0] raw_a[2];
  logic [15:0] raw_b[4];
  logic [23:0] st_a;
  logic [63:0] st_b;
  int ptr_a = 0;
  int ptr_b = 0;
  assign st_a = {raw_a[1], raw_a[0]};
  assign st_b = {raw_b[3], raw_b[2], raw_b[1], raw_b[0]};
  assign jd_a = ptr_a < 24 ? st_a[ptr_a[4:0]] : 1'b0;
  assign jd_b = ptr_b < 64 ? st_b[ptr_b[5:0]] : 1'b0;
  always @(negedge jl_a or posedge jc_a) if (!jl_a) ptr_a = 0; else ptr_a = ptr_a + 1;
  always @(negedge jl_b or posedge jc_b) if (!jl_b) ptr_b = 0; else ptr_b = ptr_b + 1;
  int ldc_a = 0, ldf_a = 0, pul_a = 0, fdn_a = 0, pul_b = 0;
  always @(negedge clk) begin
    if (!jl_a) ldc_a++;
    if (fd_a) fdn_a++;
  end
  always @(negedge jl_a) ldf_a++;
  always @(negedge jc_a) pul_a++;
  always @(negedge jc_b) pul_b++;
  logic [15:0] hist_a[2][$];
  logic [15:0] exp_a[2];
  logic [1:0]  exp_pr_a;
  task automatic reset_model_a();
    hist_a[0].delete();
    hist_a[1].delete();
    exp_a[0] = '0;
    exp_a[1] = '0;
    exp_pr_a = '0;
  endtask
  task automatic model_frame_a();
    for (int p = 0; p < 2; p++) begin
      logic [15:0] c;
      bit same;
      c = raw_a[p] == 12'h000 ? 16'h0 : {4'h0, ~raw_a[p]};
      hist_a[p].push_back(c);
      exp_pr_a[p] = raw_a[p] != 12'h000;
      if (hist_a[p].size() >= DA) begin
        same = 1;
        for (int k = 1; k <= DA; k++) if (hist_a[p][hist_a[p].size() - k] != c) same = 0;
        if (same) exp_a[p] = c;
      end
    end
  endtask
  task automatic wait_frame_a();
    int t = 0;
    do begin @(negedge clk); t++; end while (!fd_a && t < 3000);
    if (!fd_a) begin
      total++;
      $display("FAIL frame_a_timeout: no frame_done within %0d cycles, required one", t);
    end else model_frame_a();
  endtask
  task automatic wait_frame_b();
    int t = 0;
    do begin @(negedge clk); t++; end while (!fd_b && t < 3000);
    if (!fd_b) begin
      total++;
      $display("FAIL frame_b_timeout: no frame_done within %0d cycles, required one", t);
    end
  endtask
  task automatic wait_load_a();
    int t = 0;
    while (jl_a && t < 3000) begin @(negedge clk); t++; end
    if (jl_a) begin
      total++;
      $display("FAIL load_a_timeout: joy_load stayed %b, required 0", jl_a);
    end
  endtask
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    raw_a[0] = 12'hFFE; raw_a[1] = 12'hF7F;
    for (int p = 0; p < 4; p++) raw_b[p] = 16'hFFFF;
    #3; rst_a = 1'b0; rst_b = 1'b0;
    #1;
    total++; if ({jc_a, jl_a, fd_a} !== 3'b110) $display("FAIL rst_lines_a: got %b, required 110", {jc_a, jl_a, fd_a}); else pass_cnt++;
    total++; if ({pr_a, js_a} !== 34'h0) $display("FAIL rst_out_a: got %h, required 0", {pr_a, js_a}); else pass_cnt++;
    total++; if ({jc_b, jl_b, fd_b} !== 3'b110) $display("FAIL rst_lines_b: got %b, required 110", {jc_b, jl_b, fd_b}); else pass_cnt++;
    total++; if ({pr_b, js_b} !== 68'h0) $display("FAIL rst_out_b: got %h, required 0", {pr_b, js_b}); else pass_cnt++;
    repeat (5) @(negedge clk);
    total++; if ({jc_a, jl_a, fd_a, pr_a, js_a} !== {3'b110, 34'h0}) $display("FAIL rst_hold_a: got %h, required %h", {jc_a, jl_a, fd_a, pr_a, js_a}, {3'b110, 34'h0}); else pass_cnt++;
    reset_model_a();
  endtask
  task automatic test_single_frame();
    int l0, p0;
    l0 = ldc_a; p0 = pul_a;
    rst_a = 1'b1; en_a = 1'b1;
    wait_frame_a();
    total++; if (ldc_a - l0 !== 4) $display("FAIL load_width: got %0d cycles, required 4", ldc_a - l0); else pass_cnt++;
    total++; if (pul_a - p0 !== 24) $display("FAIL pulses_a: got %0d, required 24", pul_a - p0); else pass_cnt++;
    total++; if (pr_a !== 2'b11) $display("FAIL present_a: got %b, required 11", pr_a); else pass_cnt++;
    total++; if (js_a !== {exp_a[1], exp_a[0]}) $display("FAIL js_frame1: got %h, required %h", js_a, {exp_a[1], exp_a[0]}); else pass_cnt++;
    @(negedge clk);
    total++; if (fd_a !== 1'b0) $display("FAIL fd_pulse: got %b, required 0", fd_a); else pass_cnt++;
    for (int f = 0; f < 2; f++) begin
      p0 = pul_a;
      wait_frame_a();
      total++; if (pul_a - p0 !== 24) $display("FAIL pulses_a_f%0d: got %0d, required 24", f, pul_a - p0); else pass_cnt++;
      total++; if (js_a !== {exp_a[1], exp_a[0]}) $display("FAIL js_settle_f%0d: got %h, required %h", f, js_a, {exp_a[1], exp_a[0]}); else pass_cnt++;
    end
    total++; if (js_a !== 32'h0080_0001) $display("FAIL js_settled: got %h, required 00800001", js_a); else pass_cnt++;
  endtask
  task automatic test_debounce();
    logic [11:0] seq[6];
    seq = '{12'hFEF, 12'hFEF, 12'hFFE, 12'hFEF, 12'hFEF, 12'hFEF};
    for (int f = 0; f < 6; f++) begin
      raw_a[0] = seq[f];
      wait_frame_a();
      total++; if (js_a !== {exp_a[1], exp_a[0]}) $display("FAIL debounce_f%0d: got %h, required %h", f, js_a, {exp_a[1], exp_a[0]}); else pass_cnt++;
    end
    total++; if (js_a[15:0] !== 16'h0010) $display("FAIL debounce_final: got %h, required 0010", js_a[15:0]); else pass_cnt++;
  endtask
  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 2) == 0) raw_a[p] = $urandom_range(0, 3) == 0 ? 12'h000 : 12'($urandom);
      wait_frame_a();
      total++; if (js_a !== {exp_a[1], exp_a[0]}) $display("FAIL rand_js_f%0d: got %h, required %h", f, js_a, {exp_a[1], exp_a[0]}); else pass_cnt++;
      total++; if (pr_a !== exp_pr_a) $display("FAIL rand_pr_f%0d: got %b, required %b", f, pr_a, exp_pr_a); else pass_cnt++;
    end
  endtask
  task automatic test_enable_drop();
    int p0, f0, l0, t;
    wait_load_a();
    p0 = pul_a; t = 0;
    while (pul_a - p0 < 7 && t < 1000) begin @(negedge clk); t++; end
    en_a = 1'b0;
    f0 = fdn_a; l0 = ldf_a;
    wait_frame_a();
    total++; if (pul_a - p0 !== 24) $display("FAIL drop_pulses: got %0d, required 24", pul_a - p0); else pass_cnt++;
    total++; if (js_a !== {exp_a[1], exp_a[0]}) $display("FAIL drop_js: got %h, required %h", js_a, {exp_a[1], exp_a[0]}); else pass_cnt++;
    repeat (400) @(negedge clk);
    total++; if (fdn_a - f0 !== 1) $display("FAIL drop_fd_once: got %0d pulses, required 1", fdn_a - f0); else pass_cnt++;
    total++; if (ldf_a !== l0) $display("FAIL drop_no_load: got %0d loads, required %0d", ldf_a, l0); else pass_cnt++;
    en_a = 1'b1; t = 0;
    while (jl_a && t < 20) begin @(negedge clk); t++; end
    total++; if (jl_a !== 1'b0 || t > CD) $display("FAIL reenable_load: got load=%b after %0d cycles, required 0 within %0d", jl_a, t, CD); else pass_cnt++;
    wait_frame_a();
    total++; if (js_a !== {exp_a[1], exp_a[0]}) $display("FAIL reenable_js: got %h, required %h", js_a, {exp_a[1], exp_a[0]}); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    int p0, t;
    raw_a[0] = 12'hFFD; raw_a[1] = 12'hBFF;
    wait_frame_a();
    wait_load_a();
    p0 = pul_a; t = 0;
    while (pul_a - p0 < 5 && t < 1000) begin @(negedge clk); t++; end
    #2 rst_a = 1'b0;
    #1;
    total++; if ({jc_a, jl_a, fd_a} !== 3'b110) $display("FAIL mid_rst_lines: got %b, required 110", {jc_a, jl_a, fd_a}); else pass_cnt++;
    total++; if ({pr_a, js_a} !== 34'h0) $display("FAIL mid_rst_out: got %h, required 0", {pr_a, js_a}); else pass_cnt++;
    reset_model_a();
    @(negedge clk); rst_a = 1'b1;
    wait_frame_a();
    total++; if (js_a !== 32'h0) $display("FAIL post_rst_js1: got %h, required 0", js_a); else pass_cnt++;
    total++; if (pr_a !== 2'b11) $display("FAIL post_rst_pr: got %b, required 11", pr_a); else pass_cnt++;
    wait_frame_a();
    wait_frame_a();
    total++; if (js_a !== 32'h0400_0002) $display("FAIL post_rst_js3: got %h, required 04000002", js_a); else pass_cnt++;
  endtask
  task automatic test_scaling();
    logic [15:0] expb[4];
    int p0;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 4; p++) begin
        expb[p] = 16'h1 << (4 * p + int'($urandom_range(0, 3)));
        raw_b[p] = ~expb[p];
      end
      p0 = pul_b;
      if (f == 0) begin @(negedge clk); rst_b = 1'b1; en_b = 1'b1; end
      wait_frame_b();
      total++; if (pul_b - p0 !== 64) $display("FAIL scale_pulses_f%0d: got %0d, required 64", f, pul_b - p0); else pass_cnt++;
      total++; if (pr_b !== 4'hF) $display("FAIL scale_pr_f%0d: got %b, required 1111", f, pr_b); else pass_cnt++;
      for (int p = 0; p < 4; p++) begin
        total++; if (js_b[16*p +: 16] !== expb[p]) $display("FAIL scale_js_f%0d_p%0d: got %h, required %h", f, p, js_b[16*p +: 16], expb[p]); else pass_cnt++;
      end
    end
  endtask
  task automatic test_absent();
    logic [15:0] keep0, keep2;
    keep0 = ~raw_b[0]; keep2 = ~raw_b[2];
    raw_b[1] = 16'h0000;
    wait_frame_b();
    total++; if (pr_b !== 4'b1101) $display("FAIL absent_pr: got %b, required 1101", pr_b); else pass_cnt++;
    total++; if (js_b[31:16] !== 16'h0) $display("FAIL absent_js1: got %h, required 0", js_b[31:16]); else pass_cnt++;
    total++; if (js_b[15:0] !== keep0) $display("FAIL absent_js0: got %h, required %h", js_b[15:0], keep0); else pass_cnt++;
    total++; if (js_b[47:32] !== keep2) $display("FAIL absent_js2: got %h, required %h", js_b[47:32], keep2); else pass_cnt++;
    raw_b[1] = 16'hFFFF;
    wait_frame_b();
    total++; if (pr_b !== 4'hF) $display("FAIL released_pr: got %b, required 1111", pr_b); else pass_cnt++;
    total++; if (js_b[31:16] !== 16'h0) $display("FAIL released_js1: got %h, required 0", js_b[31:16]); else pass_cnt++;
    en_b = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_debounce();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_scaling();
    test_absent();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
